// File: rtl/regfile_hilo_md_if.sv
// Bus bundle for regfile_hilo_md: register read/write ports, mult/div handshake and HI/LO access.
interface regfile_hilo_md_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              md_start;
    logic [1:0]        md_op;
    logic [DATA_W-1:0] md_a, md_b;
    logic              md_busy, md_done;
    logic              hi_we, lo_we;
    logic [DATA_W-1:0] hilo_wdata;
    logic [DATA_W-1:0] hi, lo;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata,
        input  rd_data_a, rd_data_b, md_busy, md_done, hi, lo
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
               md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata,
        output rd_data_a, rd_data_b, md_busy, md_done, hi, lo
    );
endinterface

// File: rtl/regfile_hilo_md.sv
// Two-read/one-write register file with HI/LO and an iterative one-bit-per-cycle mult/div unit.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle register and HI/LO writes to the outputs.
module regfile_hilo_md #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic            clock,
    input logic            reset,
    regfile_hilo_md_if.slave bus
);
    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] p_q, p_d;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   opnd_q, opnd_d; // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   a_q, a_d;       // raw dividend, returned in HI on divide by zero
    logic                div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [DATA_W-1:0]   ma, mb, sub;
    logic [DATA_W:0]     shifted, sum;
    logic                ge;

    assign ma      = (bus.md_op[0] && bus.md_a[DATA_W-1]) ? -bus.md_a : bus.md_a;
    assign mb      = (bus.md_op[0] && bus.md_b[DATA_W-1]) ? -bus.md_b : bus.md_b;
    assign shifted = p_q[2*DATA_W-1:DATA_W-1];
    assign ge      = shifted >= {1'b0, opnd_q};
    assign sub     = shifted[DATA_W-1:0] - opnd_q;
    assign sum     = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, opnd_q} : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        opnd_d  = opnd_q;
        a_d     = a_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.hilo_wdata;
                if (bus.lo_we) lo_d = bus.hilo_wdata;
                if (bus.md_start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    div_d   = bus.md_op[1];
                    a_d     = bus.md_a;
                    qneg_d  = bus.md_op[0] & (bus.md_a[DATA_W-1] ^ bus.md_b[DATA_W-1]);
                    rneg_d  = bus.md_op[0] & bus.md_a[DATA_W-1];
                    dz_d    = bus.md_op[1] & (bus.md_b == '0);
                    opnd_d  = bus.md_op[1] ? mb : ma;
                    p_d     = {{DATA_W{1'b0}}, (bus.md_op[1] ? ma : mb)};
                end
            end
            S_RUN: begin
                if (div_q) p_d = {(ge ? sub : shifted[DATA_W-1:0]), p_q[DATA_W-2:0], ge};
                else       p_d = {sum, p_q[DATA_W-1:1]};
                cnt_d = cnt_q + 1'b1;
                // Last iteration: sign-fix the magnitudes straight into HI/LO.
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_DONE;
                    if (!div_q) begin
                        {hi_d, lo_d} = qneg_q ? -p_d : p_d;
                    end else if (dz_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = qneg_q ? -p_d[DATA_W-1:0] : p_d[DATA_W-1:0];
                        hi_d = rneg_q ? -p_d[2*DATA_W-1:DATA_W] : p_d[2*DATA_W-1:DATA_W];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            opnd_q  <= opnd_d;
            a_q     <= a_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (bus.wr_en && bus.wr_addr != '0) regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    logic [DATA_W-1:0] rd_a_raw, rd_b_raw;
    assign rd_a_raw    = (bus.rd_addr_a == '0) ? '0 : regs_q[bus.rd_addr_a];
    assign rd_b_raw    = (bus.rd_addr_b == '0) ? '0 : regs_q[bus.rd_addr_b];
    assign bus.md_busy = (state_q == S_RUN);
    assign bus.md_done = (state_q == S_DONE);

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live       = bus.wr_en && (bus.wr_addr != '0);
    assign bus.rd_data_a = (wr_live && bus.rd_addr_a == bus.wr_addr) ? bus.wr_data : rd_a_raw;
    assign bus.rd_data_b = (wr_live && bus.rd_addr_b == bus.wr_addr) ? bus.wr_data : rd_b_raw;
    assign bus.hi        = (state_q == S_IDLE && bus.hi_we) ? bus.hilo_wdata : hi_q;
    assign bus.lo        = (state_q == S_IDLE && bus.lo_we) ? bus.hilo_wdata : lo_q;
`else
    assign bus.rd_data_a = rd_a_raw;
    assign bus.rd_data_b = rd_b_raw;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
`endif
endmodule

// File: tb/tb_regfile_hilo_md.sv
// Randomized scoreboard bench for regfile_hilo_md: arithmetic reference model, queue of expected HI:LO results.
module tb_regfile_hilo_md;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clock = 1'b0;
    logic reset;
    regfile_hilo_md_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_hilo_md #(.DATA_W(DW), .ADDR_W(AW)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_errors = 0;
    int            busy_cnt = 0;
    logic [DW-1:0] m_regs [1<<AW];
    logic [DW-1:0] m_hi, m_lo;
    logic [63:0]   exp_q [$];
    logic [63:0]   mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % already truncate toward zero.
    function automatic logic [63:0] md_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00:   return {32'd0, a} * {32'd0, b};
            2'b01:   return 64'(sa * sb);
            2'b10:   return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: return (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
        endcase
    endfunction

    always @(negedge clock) begin
        if (reset) busy_cnt = 0;
        else begin
            if (bus.md_busy) busy_cnt++;
            if (bus.md_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: md_done=1 with no operation outstanding");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("md_result", {bus.hi, bus.lo}, mon_e);
                    chk("md_busy_cycles", 64'(busy_cnt), 64'd32);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit mid_start, input bit wr_start);
        logic [63:0] r;
        logic [31:0] old_hi, old_lo, w;
        bit          seen;
        r = md_ref(op, a, b);
        w = $urandom;
        bus.md_start = 1'b1; bus.md_op = op; bus.md_a = a; bus.md_b = b;
        if (wr_start) begin
            bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = w;
            m_hi = w; m_lo = w;
        end
        exp_q.push_back(r);
        step();
        bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.md_op = 2'($urandom); bus.md_a = $urandom; bus.md_b = $urandom;
        settle();
        chk("busy_after_start", 64'(bus.md_busy), 64'd1);
        if (wr_start) chk("hilo_write_with_start", {bus.hi, bus.lo}, {w, w});
        old_hi = m_hi; old_lo = m_lo;
        for (int i = 0; i < 5; i++) step();
        if (mid_start) begin
            bus.md_start = 1'b1; bus.md_op = ~op; bus.md_a = $urandom; bus.md_b = $urandom;
            step();
            bus.md_start = 1'b0;
        end
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = $urandom;
        step(); step();
        chk("hilo_ignored_in_run", {bus.hi, bus.lo}, {old_hi, old_lo});
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.md_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = $urandom;
            step();
            bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            settle();
            chk("hilo_ignored_in_done", {bus.hi, bus.lo}, r);
        end
        m_hi = r[63:32]; m_lo = r[31:0];
    endtask

    initial begin
        logic [31:0] ea, eb;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.md_start = 1'b0; bus.md_op = '0; bus.md_a = '0; bus.md_b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.hilo_wdata = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        foreach (m_regs[i]) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;
        bus.rd_addr_a = 5'd7;
        settle();
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_busy_done", {62'd0, bus.md_busy, bus.md_done}, 64'd0);
        chk("reset_reg", 64'(bus.rd_data_a), 64'd0);

        // Same-cycle visibility of a register write, then the committed value.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.rd_addr_a = 5'd5;
        settle();
`ifdef REGFILE_BYPASS_EN
        chk("r5_same_cycle", 64'(bus.rd_data_a), 64'hDEADBEEF);
`else
        chk("r5_same_cycle", 64'(bus.rd_data_a), 64'd0);
`endif
        step();
        bus.wr_en = 1'b0;
        m_regs[5] = 32'hDEADBEEF;
        settle();
        chk("r5_next_cycle", 64'(bus.rd_data_a), 64'hDEADBEEF);

        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h00001234; bus.rd_addr_a = 5'd0;
        settle();
        chk("r0_same_cycle", 64'(bus.rd_data_a), 64'd0);
        step();
        bus.wr_en = 1'b0;
        settle();
        chk("r0_after_write", 64'(bus.rd_data_a), 64'd0);

        for (int it = 0; it < 40; it++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = (it % 7 == 0) ? 5'd0 : 5'($urandom);
            bus.wr_data   = $urandom;
            bus.rd_addr_a = (it % 7 == 0) ? 5'd0 : 5'($urandom);
            bus.rd_addr_b = (it % 3 == 0) ? bus.wr_addr : 5'($urandom);
            settle();
            ea = m_regs[bus.rd_addr_a];
            eb = m_regs[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && bus.wr_addr != 0 && bus.rd_addr_a == bus.wr_addr) ea = bus.wr_data;
            if (bus.wr_en && bus.wr_addr != 0 && bus.rd_addr_b == bus.wr_addr) eb = bus.wr_data;
`endif
            chk("rand_rd_a", 64'(bus.rd_data_a), 64'(ea));
            chk("rand_rd_b", 64'(bus.rd_data_b), 64'(eb));
            step();
            if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
        end
        bus.wr_en = 1'b0;

        // Direct HI/LO writes: hi only, lo only, both.
        for (int k = 1; k <= 3; k++) begin
            bus.hi_we = k[0]; bus.lo_we = k[1]; bus.hilo_wdata = $urandom;
            settle();
`ifdef REGFILE_BYPASS_EN
            chk("hilo_same_cycle", {bus.hi, bus.lo},
                {(k[0] ? bus.hilo_wdata : m_hi), (k[1] ? bus.hilo_wdata : m_lo)});
`else
            chk("hilo_same_cycle", {bus.hi, bus.lo}, {m_hi, m_lo});
`endif
            step();
            if (k[0]) m_hi = bus.hilo_wdata;
            if (k[1]) m_lo = bus.hilo_wdata;
            bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            settle();
            chk("hilo_direct", {bus.hi, bus.lo}, {m_hi, m_lo});
        end

        run_md(2'b01, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        run_md(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        run_md(2'b10, 32'd100, 32'd0, 1'b0, 1'b1);
        run_md(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_md(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_md(2'b11, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            run_md(2'($urandom), $urandom, (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 9)) : $urandom),
                   1'(i % 3 == 0), 1'(i % 5 == 0));

        // Abort a multu mid-run with reset.
        bus.md_start = 1'b1; bus.md_op = 2'b00; bus.md_a = 32'd5; bus.md_b = 32'd6;
        step();
        bus.md_start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.rd_addr_a = 5'd5;
        settle();
        chk("abort_busy", 64'(bus.md_busy), 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("abort_reg_cleared", 64'(bus.rd_data_a), 64'd0);
        for (int i = 0; i < 40; i++) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_hilo_md.md
REGFILE_HILO_MD -- requirements
Module: regfile_hilo_md

Interface
REQ-001 The module SHALL take parameter DATA_W, default 32, meaning register and HI/LO data width (even, >=8).
REQ-002 The module SHALL take parameter ADDR_W, default 5, meaning register index width (2^ADDR_W registers).
REQ-003 clock  input  1  the clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd_addr_a, rd_addr_b  input  ADDR_W each  read port indices.
REQ-006 rd_data_a, rd_data_b  output  DATA_W each  read port data, combinational.
REQ-007 wr_en  input  1  register write strobe.
REQ-008 wr_addr  input  ADDR_W  write index.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 md_start  input  1  start request for a mult/div operation.
REQ-011 md_op  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
REQ-012 md_a, md_b  input  DATA_W each  operands: multiplicand/multiplier or dividend/divisor.
REQ-013 md_busy  output  1  operation in progress.
REQ-014 md_done  output  1  one-cycle completion pulse.
REQ-015 hi_we, lo_we  input  1 each  direct HI/LO write strobes (mthi/mtlo).
REQ-016 hilo_wdata  input  DATA_W  direct HI/LO write data.
REQ-017 hi, lo  output  DATA_W each  current HI and LO register contents.

Function
REQ-018 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded.
REQ-019 A write with wr_en=1 SHALL update the register at the rising clock edge; both read ports SHALL be able to read any index in the same cycle.
REQ-020 md_start SHALL be accepted only when md_busy=0; md_start while md_busy=1 SHALL be ignored with no effect on the running operation.
REQ-021 FSM states: IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE after exactly DATA_W iteration cycles; DONE->IDLE unconditionally after one cycle.
REQ-022 md_busy SHALL be 1 in RUN only; md_done SHALL be 1 in DONE only; HI/LO SHALL be written at the edge entering DONE.
REQ-023 Operands and md_op SHALL be latched at acceptance; later changes to the inputs SHALL NOT affect the result.
REQ-024 Multiply SHALL be iterative shift-add, one bit per cycle; HI:LO = full 2*DATA_W-bit product; signed variant via magnitude conversion and final negation.
REQ-025 Divide SHALL be restoring, one quotient bit per cycle; LO = quotient, HI = remainder; signed variant truncates toward zero, remainder takes the dividend's sign.
REQ-026 Divide by zero SHALL produce LO = all ones, HI = dividend, with the same latency.
REQ-027 hi_we/lo_we SHALL update HI/LO at the edge when md_busy=0 and not in DONE; when md_busy=1 or in DONE they SHALL be ignored.
REQ-028 Simultaneous hi_we and lo_we SHALL write hilo_wdata to both registers; a direct write together with an accepted md_start SHALL take effect, and the operation result SHALL overwrite it later.

Reset
REQ-029 Reset SHALL clear all registers, HI and LO to 0, force the FSM to IDLE, and drive md_busy=0 and md_done=0 at the next edge.
REQ-030 Reset during RUN SHALL abort the operation with no md_done pulse and no HI/LO update other than clearing.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: a read of index != 0 equal to wr_addr while wr_en=1 SHALL return wr_data in that same cycle; hi/lo SHALL likewise reflect an enabled direct write in its cycle.
REQ-032 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value.

Verification (DATA_W=32, ADDR_W=5)
REQ-033 wr r5=0xDEADBEEF, read rd_addr_a=5 in the same cycle -> 0xDEADBEEF with bypass, 0x00000000 without; next cycle 0xDEADBEEF in both.
REQ-034 wr r0=0x00001234 -> rd_data_a at index 0 reads 0x00000000.
REQ-035 mult, md_a=0xFFFFFFFD (-3), md_b=7 -> md_busy high 32 cycles, md_done one cycle, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 div, md_a=0xFFFFFFF9 (-7), md_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; a second md_start mid-run is ignored.
REQ-037 divu, md_a=100, md_b=0 -> LO=0xFFFFFFFF, HI=0x00000064 after 32 busy cycles.
REQ-038 reset asserted in cycle 10 of a multu 5x6 -> next cycle md_busy=0, HI=LO=0, md_done never pulses.
